// File: rtl/uart_regs_pkg.sv
// Register map, status bit positions and access FSM states
// for the Avalon-MM UART responder.
package uart_regs_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int TX_OK_BIT  = 6;
    localparam int RX_OK_BIT  = 7;
    localparam int TX_OVR_BIT = 1;
    localparam int RX_UDR_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } acc_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with push/pop in the same cycle
// and an occupancy counter one bit wider than the pointers.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rptr];
    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(DEPTH));

    always_ff @(posedge avm_clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avm_uart_responder.sv
// Avalon-MM slave emulating the RS232 UART register map, with
// RX/TX byte FIFOs bridging to valid/ready byte streams.
module avm_uart_responder
    import uart_regs_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    input  logic [7:0]  rx_byte_data,
    input  logic        rx_byte_valid,
    output logic        rx_byte_ready,
    output logic [7:0]  tx_byte_data,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    acc_state_e    r_state;
    acc_state_e    w_state_nxt;
    logic [CW-1:0] r_wcnt;
    logic [4:0]    r_addr;
    logic          r_is_rd;
    logic [7:0]    r_wdata;
    logic [31:0]   r_rdata;
    logic          r_do_rx_pop;
    logic          r_do_tx_push;
    logic          r_set_udr;
    logic          r_set_ovr;
    logic          r_clr_sticky;
    logic          r_rx_udr;
    logic          r_tx_ovr;

    logic          w_req;
    logic          w_last;
    logic          w_ack;
    logic          w_waitreq;
    logic [31:0]   w_snap;
    logic [7:0]    w_rx_dout;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_rx_pop;
    logic          w_tx_push;

    assign w_req = avs_read || avs_write;
    assign w_ack = (r_state == ACK);

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_waitreq   = 1'b1;
        w_last      = 1'b0;
        unique case (r_state)
            IDLE: if (w_req) w_state_nxt = WAIT;
            WAIT: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                end else if (r_wcnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_waitreq   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Readdata is built from the FIFO/flag state sampled on the final wait cycle
    always_comb begin
        w_snap = '0;
        if (r_is_rd) begin
            if (r_addr == RX_BASE && !w_rx_empty) begin
                w_snap[7:0] = w_rx_dout;
            end else if (r_addr == STATUS_BASE) begin
                w_snap[RX_OK_BIT]  = !w_rx_empty;
                w_snap[TX_OK_BIT]  = !w_tx_full;
                w_snap[TX_OVR_BIT] = r_tx_ovr;
                w_snap[RX_UDR_BIT] = r_rx_udr;
            end
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_wcnt       <= '0;
            r_addr       <= '0;
            r_is_rd      <= 1'b0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_do_rx_pop  <= 1'b0;
            r_do_tx_push <= 1'b0;
            r_set_udr    <= 1'b0;
            r_set_ovr    <= 1'b0;
            r_clr_sticky <= 1'b0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_addr  <= avs_address;
                r_is_rd <= avs_read;
                r_wdata <= avs_writedata[7:0];
                r_wcnt  <= '0;
            end else if (r_state == WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            // Side effects are decided against the same snapshot as readdata
            if (w_last) begin
                r_rdata      <= w_snap;
                r_do_rx_pop  <= r_is_rd && r_addr == RX_BASE && !w_rx_empty;
                r_set_udr    <= r_is_rd && r_addr == RX_BASE && w_rx_empty;
                r_clr_sticky <= r_is_rd && r_addr == STATUS_BASE;
                r_do_tx_push <= !r_is_rd && r_addr == TX_BASE && !w_tx_full;
                r_set_ovr    <= !r_is_rd && r_addr == TX_BASE && w_tx_full;
            end else if (w_ack) begin
                r_rdata      <= '0;
                r_do_rx_pop  <= 1'b0;
                r_set_udr    <= 1'b0;
                r_clr_sticky <= 1'b0;
                r_do_tx_push <= 1'b0;
                r_set_ovr    <= 1'b0;
            end
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_udr <= 1'b0;
            r_tx_ovr <= 1'b0;
        end else if (w_ack) begin
            if (r_clr_sticky) begin
                r_rx_udr <= 1'b0;
                r_tx_ovr <= 1'b0;
            end else begin
                if (r_set_udr) r_rx_udr <= 1'b1;
                if (r_set_ovr) r_tx_ovr <= 1'b1;
            end
        end
    end

    assign w_rx_pop  = w_ack && r_do_rx_pop;
    assign w_tx_push = w_ack && r_do_tx_push;

    assign avs_waitrequest = w_waitreq;
    assign avs_readdata    = r_rdata;
    assign rx_byte_ready   = !w_rx_full;
    assign tx_byte_valid   = !w_tx_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .push    (rx_byte_valid),
        .pop     (w_rx_pop),
        .din     (rx_byte_data),
        .dout    (w_rx_dout),
        .empty   (w_rx_empty),
        .full    (w_rx_full)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .push    (w_tx_push),
        .pop     (tx_byte_ready),
        .din     (r_wdata),
        .dout    (tx_byte_data),
        .empty   (w_tx_empty),
        .full    (w_tx_full)
    );

endmodule

// File: tb/tb_avm_uart_responder.sv
// Directed bench for avm_uart_responder: register map, FIFOs,
// sticky flags, stream handshakes and mid-access reset.
module tb_avm_uart_responder;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  rx_byte_data = '0;
    logic        rx_byte_valid = 1'b0;
    logic        rx_byte_ready;
    logic [7:0]  tx_byte_data;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 avm_clk = ~avm_clk;

    avm_uart_responder #(.FIFO_DEPTH(16), .WAIT_CYCLES(1)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .rx_byte_data    (rx_byte_data),
        .rx_byte_valid   (rx_byte_valid),
        .rx_byte_ready   (rx_byte_ready),
        .tx_byte_data    (tx_byte_data),
        .tx_byte_valid   (tx_byte_valid),
        .tx_byte_ready   (tx_byte_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic rd, input logic [4:0] a,
                          input logic [7:0] wd, output logic [31:0] rdata);
        int n;
        n = 0;
        @(posedge avm_clk);
        #1;
        avs_address   = a;
        avs_read      = rd;
        avs_write     = !rd;
        avs_writedata = {24'h0, wd};
        @(negedge avm_clk);
        while (avs_waitrequest && n < 40) begin
            @(negedge avm_clk);
            n++;
        end
        rdata = avs_readdata;
        chk("latency", n, 2);
        @(posedge avm_clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        @(negedge avm_clk);
        chk("wrq_after_ack", {31'b0, avs_waitrequest}, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        access(1'b1, a, 8'h00, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] wd);
        logic [31:0] d;
        access(1'b0, a, wd, d);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(posedge avm_clk);
        #1;
        rx_byte_data  = b;
        rx_byte_valid = 1'b1;
        @(posedge avm_clk);
        #1;
        rx_byte_valid = 1'b0;
    endtask

    initial begin
        int pushes;
        repeat (3) @(negedge avm_clk);
        chk("rst_wrq", {31'b0, avs_waitrequest}, 1);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_rx_ready", {31'b0, rx_byte_ready}, 1);
        chk("rst_tx_valid", {31'b0, tx_byte_valid}, 0);
        avm_rst = 1'b0;

        rd_chk("status_reset", 5'd8, 32'h40);

        rx_push(8'hA5);
        rx_push(8'h3C);
        rd_chk("status_rx2", 5'd8, 32'hC0);
        rd_chk("rx_pop0", 5'd0, 32'hA5);
        rd_chk("rx_pop1", 5'd0, 32'h3C);
        rd_chk("status_rx0", 5'd8, 32'h40);

        for (int i = 0; i < 16; i++) wr(5'd4, 8'(8'h11 + i));
        rd_chk("status_txfull", 5'd8, 32'h00);
        wr(5'd4, 8'h99);
        rd_chk("status_ovr", 5'd8, 32'h02);
        rd_chk("status_ovr_clr", 5'd8, 32'h00);

        @(posedge avm_clk);
        #1;
        tx_byte_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge avm_clk);
            chk("tx_valid", {31'b0, tx_byte_valid}, 1);
            chk("tx_data", {24'b0, tx_byte_data}, 32'(8'h11 + i));
        end
        @(negedge avm_clk);
        chk("tx_drained", {31'b0, tx_byte_valid}, 0);
        tx_byte_ready = 1'b0;

        rd_chk("rx_empty_read", 5'd0, 32'h00);
        rd_chk("status_udr", 5'd8, 32'h41);
        rd_chk("status_udr_clr", 5'd8, 32'h40);

        pushes = 0;
        @(posedge avm_clk);
        #1;
        rx_byte_data  = 8'h80;
        rx_byte_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge avm_clk);
            if (rx_byte_ready) pushes++;
            @(posedge avm_clk);
            #1;
            rx_byte_data = rx_byte_data + 8'h01;
        end
        @(negedge avm_clk);
        chk("rx_pushes", pushes, 16);
        chk("rx_ready_full", {31'b0, rx_byte_ready}, 0);
        rx_byte_valid = 1'b0;
        rd_chk("status_rxfull", 5'd8, 32'hC0);
        rd_chk("rx_full_head", 5'd0, 32'h80);

        @(posedge avm_clk);
        #1;
        avs_address   = 5'd4;
        avs_write     = 1'b1;
        avs_writedata = 32'h55;
        @(posedge avm_clk);
        #1;
        avm_rst = 1'b1;
        avs_write = 1'b0;
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        chk("rst_mid_tx_valid", {31'b0, tx_byte_valid}, 0);
        chk("rst_mid_wrq", {31'b0, avs_waitrequest}, 1);
        rd_chk("status_after_rst", 5'd8, 32'h40);
        chk("rst_tx_valid_end", {31'b0, tx_byte_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
